// File: rtl/aes128_key_schedule.sv
// ============================================================================
// Module   : aes128_key_schedule
// Purpose  : Iterative AES-128 key expansion, one round key per clock, with
//            all 11 round keys on a packed bus.
//            Optional macro KEYEXP_RESTART_EN: start is honoured in DONE.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes128_key_schedule (
    input  logic           clk,
    input  logic           rst,
    input  logic [127:0]   key,
    input  logic           start,
    output logic [1407:0]  out,
    output logic           finish
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [127:0]  rk_q, rk_d;
    logic [1407:0] out_q, out_d;
    logic          finish_q, finish_d;

    logic          load;
    logic [7:0]    rcon;
    logic [31:0]   rot, temp;
    logic [31:0]   w0n, w1n, w2n, w3n;
    logic [127:0]  rk_next;

`ifdef KEYEXP_RESTART_EN
    assign load = start && ((state_q == S_IDLE) || (state_q == S_DONE));
`else
    assign load = start && (state_q == S_IDLE);
`endif

    always_comb begin
        rcon = 8'h00;
        case (cnt_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // RotWord then SubWord on w3, Rcon folded into the leading byte.
    assign rot  = {rk_q[23:0], rk_q[31:24]};
    assign temp = {sbox_lookup(rot[31:24]) ^ rcon, sbox_lookup(rot[23:16]),
                   sbox_lookup(rot[15:8]), sbox_lookup(rot[7:0])};
    assign w0n  = rk_q[127:96] ^ temp;
    assign w1n  = rk_q[95:64]  ^ w0n;
    assign w2n  = rk_q[63:32]  ^ w1n;
    assign w3n  = rk_q[31:0]   ^ w2n;
    assign rk_next = {w0n, w1n, w2n, w3n};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_EXPAND;
            S_EXPAND: if (cnt_q == 4'd10) state_d = S_DONE;
`ifdef KEYEXP_RESTART_EN
            S_DONE:   if (start) state_d = S_EXPAND;
`else
            S_DONE:   state_d = S_DONE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        rk_d     = rk_q;
        out_d    = out_q;
        finish_d = finish_q;
        if (load) begin
            out_d    = {key, 1280'b0};
            rk_d     = key;
            cnt_d    = 4'd1;
            finish_d = 1'b0;
        end else if (state_q == S_EXPAND) begin
            rk_d  = rk_next;
            cnt_d = cnt_q + 4'd1;
            for (int k = 1; k <= 10; k++) begin
                if (cnt_q == 4'(k)) out_d[1407-128*k -: 128] = rk_next;
            end
            if (cnt_q == 4'd10) finish_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= 4'd0;
            rk_q     <= 128'b0;
            out_q    <= 1408'b0;
            finish_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rk_q     <= rk_d;
            out_q    <= out_d;
            finish_q <= finish_d;
        end
    end

    assign out    = out_q;
    assign finish = finish_q;

endmodule

`default_nettype wire

// File: tb/tb_aes128_key_schedule.sv
// ============================================================================
// Module   : tb_aes128_key_schedule
// Purpose  : Directed bench for aes128_key_schedule against a FIPS-197 model
//            (S-box derived from GF(2^8) inversion plus affine map).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes128_key_schedule;

    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef KEYEXP_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [127:0]  key;
    logic [1407:0] out;
    logic          finish;

    int n_vec = 0;
    int n_bad = 0;

    aes128_key_schedule dut (
        .clk    (clk),
        .rst    (rst),
        .key    (key),
        .start  (start),
        .out    (out),
        .finish (finish)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv, s;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]) ^ rc, sbox_ref(t[23:16]),
                     sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
        return r;
    endfunction

    bit            m_act = 1'b0;
    int            m_n   = 0;
    logic [1407:0] m_full = '0;
    bit            chk_en = 1'b0;

    // m_n = index of the newest round key that must be visible.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act <= 1'b0;
            m_n   <= 0;
        end else if (start && (!m_act || (RESTART && m_n == 10))) begin
            m_act  <= 1'b1;
            m_n    <= 0;
            m_full <= expand(key);
        end else if (m_act && m_n < 10) begin
            m_n <= m_n + 1;
        end
    end

    function automatic logic [1407:0] exp_out();
        if (!m_act) return '0;
        return m_full & ~({1408{1'b1}} >> (128 * (m_n + 1)));
    endfunction

    // ---------------- checking ----------------
    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bus(input string name, input logic [1407:0] act, input logic [1407:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            for (int k = 0; k <= 10; k++) begin
                if (act[1407-128*k -: 128] !== exp[1407-128*k -: 128]) begin
                    $display("FAIL %s rk%0d at %0t: got %h expected %h", name, k, $time,
                             act[1407-128*k -: 128], exp[1407-128*k -: 128]);
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_bus("out", out, exp_out());
            check128("finish", {127'b0, finish}, {127'b0, (m_act && m_n == 10)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_fin(input bit corrupt, output int n);
        n = 0;
        while (!finish && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (corrupt && n == 3) key = '1;
        end
    endtask

    task automatic run_start(input logic [127:0] k, input bit corrupt, output int n);
        @(negedge clk);
        key   = k;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_fin(corrupt, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int            n;
        logic [1407:0] ref_bus;

        // Model pinned against published FIPS-197 values.
        ref_bus = expand(KEY_FIPS);
        check128("model_fips_rk1", ref_bus[1279:1152], 128'ha0fafe1788542cb123a339392a6c7605);
        check128("model_fips_rk10", ref_bus[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        ref_bus = expand(128'h0);
        check128("model_zero_rk1", ref_bus[1279:1152], 128'h62636363626363636263636362636363);

        rst   = 1'b1;
        start = 1'b1;
        key   = KEY_FIPS;
        #1 rst = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check128("reset_out_rk0", out[1407:1280], 128'h0);
        check128("reset_out_rk10", out[127:0], 128'h0);
        check128("reset_finish", {127'b0, finish}, 128'h0);

        // Release with start held: the next edge is the start edge.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check128("fips_rk0", out[1407:1280], KEY_FIPS);
        wait_fin(1'b0, n);
        check128("fips_latency", 128'(n), 128'd10);
        check128("fips_rk1", out[1279:1152], 128'ha0fafe1788542cb123a339392a6c7605);
        check128("fips_rk10", out[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        do_reset();
        run_start(128'h0, 1'b0, n);
        check128("zero_latency", 128'(n), 128'd10);
        check128("zero_rk1", out[1279:1152], 128'h62636363626363636263636362636363);
        check128("zero_rk10", out[127:0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        do_reset();
        run_start(KEY_SEQ, 1'b1, n);
        check128("seq_rk10_keychg", out[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Asynchronous reset after the 5th expansion edge.
        do_reset();
        @(negedge clk);
        key   = KEY_FIPS;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check128("async_finish", {127'b0, finish}, 128'h0);
        check128("async_out_rk0", out[1407:1280], 128'h0);
        check128("async_out_rk5", out[767:640], 128'h0);
        @(negedge clk);
        rst = 1'b1;
        run_start(KEY_FIPS, 1'b0, n);
        check128("rerun_latency", 128'(n), 128'd10);
        check128("rerun_rk1", out[1279:1152], 128'ha0fafe1788542cb123a339392a6c7605);
        check128("rerun_rk10", out[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // start in DONE with a new key.
        @(negedge clk);
        key   = 128'h0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
`ifdef KEYEXP_RESTART_EN
        check128("restart_finish_drop", {127'b0, finish}, 128'h0);
        check128("restart_rk0", out[1407:1280], 128'h0);
        wait_fin(1'b0, n);
        check128("restart_latency", 128'(n), 128'd10);
        check128("restart_rk10", out[127:0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
`else
        repeat (12) @(negedge clk);
        check128("done_hold_finish", {127'b0, finish}, 128'h1);
        check128("done_hold_rk0", out[1407:1280], KEY_FIPS);
        check128("done_hold_rk10", out[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
